// File: rtl/mul_issue_control_pkg.sv
// Shared types for the M-extension multiply issue path.
// Provides funct3 encodings, operand sign classes, the issue FSM state
// encoding, the cached-product payload and small decode/select helpers.
package m_extension;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPW   = XLEN + 1;
    localparam int unsigned PRODW = 2 * OPW;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        SS,
        SU,
        UU
    } sign_class_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } issue_state_t;

    typedef struct packed {
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        sign_class_t       cls;
        logic [2*XLEN-1:0] product;
    } cache_entry_t;

    // Operand signedness implied by a multiply funct3.
    function automatic sign_class_t sign_class(input logic [2:0] f3);
        case (f3)
            F3_MULHSU: return SU;
            F3_MULHU:  return UU;
            default:   return SS;
        endcase
    endfunction

    // MUL returns the low word; every high-half variant returns the upper word.
    function automatic logic [XLEN-1:0] select_half(input logic [2*XLEN-1:0] p,
                                                    input logic [2:0]        f3);
        return (f3 == F3_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

endpackage

// File: rtl/mul_result_cache.sv
// One-entry product cache with hit compare.
// Ports: clk/rst; wr_en_i/wr_entry_i store an entry; inv_i drops it;
// rs1_i/rs2_i/cls_i/is_mul_i describe the lookup; hit_c_o is the
// combinational hit, product_o the stored 64-bit product.
module mul_result_cache
    import m_extension::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  cache_entry_t      wr_entry_i,
    input  logic              inv_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  sign_class_t       cls_i,
    input  logic              is_mul_i,
    output logic              hit_c_o,
    output logic [2*XLEN-1:0] product_o
);

    logic         valid_q, valid_d;
    cache_entry_t entry_q, entry_d;

    // Next-entry selection: invalidate wins over write.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (inv_i) begin
            valid_d = 1'b0;
        end else if (wr_en_i) begin
            valid_d = 1'b1;
            entry_d = wr_entry_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    // The low product word does not depend on signedness, so MUL hits any class.
    assign hit_c_o = valid_q && (rs1_i == entry_q.rs1) && (rs2_i == entry_q.rs2)
                     && ((cls_i == entry_q.cls) || is_mul_i);
    assign product_o = entry_q.product;

endmodule

// File: rtl/mul_issue_control.sv
// EX-stage initiator for the iterative multiplier.
// Inputs: EX instruction (ex_valid, ex_is_m, ex_funct3, rs1_data, rs2_data),
// flush, multiplier handshake (mul_done, mul_product).
// Outputs: mul_start/mul_a/mul_b to the multiplier, m_stall (combinational)
// to the pipeline, m_result/m_result_valid strobe, sticky timeout_err.
module mul_issue_control
    import m_extension::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_m,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             flush,
    output logic             mul_start,
    output logic [OPW-1:0]   mul_a,
    output logic [OPW-1:0]   mul_b,
    input  logic             mul_done,
    input  logic [PRODW-1:0] mul_product,
    output logic             m_stall,
    output logic [XLEN-1:0]  m_result,
    output logic             m_result_valid,
    output logic             timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    issue_state_t      state_q, state_d;
    logic              mul_start_q, mul_start_d;
    logic [OPW-1:0]    mul_a_q, mul_a_d;
    logic [OPW-1:0]    mul_b_q, mul_b_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   m_result_q, m_result_d;
    logic              m_result_valid_q, m_result_valid_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_c;
    sign_class_t       req_cls_c;
    logic              hit_c;
    logic [2*XLEN-1:0] cache_product_c;
    logic              cache_wr_c;
    cache_entry_t      cache_entry_c;
    logic              unused_prod_ext;

    assign req_c     = ex_valid & ex_is_m & ~ex_funct3[2] & ~flush;
    assign req_cls_c = sign_class(ex_funct3);

    // Guard bits of the 66-bit product never reach a 32-bit result.
    assign unused_prod_ext = ^mul_product[PRODW-1:2*XLEN];

    // The latched operands double as the cache key of the in-flight multiply.
    assign cache_entry_c.rs1     = mul_a_q[XLEN-1:0];
    assign cache_entry_c.rs2     = mul_b_q[XLEN-1:0];
    assign cache_entry_c.cls     = sign_class(f3_q);
    assign cache_entry_c.product = mul_product[2*XLEN-1:0];

    mul_result_cache u_cache (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (cache_wr_c),
        .wr_entry_i (cache_entry_c),
        .inv_i      (1'b0),
        .rs1_i      (rs1_data),
        .rs2_i      (rs2_data),
        .cls_i      (req_cls_c),
        .is_mul_i   (ex_funct3 == F3_MUL),
        .hit_c_o    (hit_c),
        .product_o  (cache_product_c)
    );

    // Issue FSM next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        mul_start_d      = 1'b0;
        mul_a_d          = mul_a_q;
        mul_b_d          = mul_b_q;
        f3_d             = f3_q;
        m_result_d       = m_result_q;
        m_result_valid_d = 1'b0;
        timeout_err_d    = timeout_err_q;
        cnt_d            = cnt_q;
        cache_wr_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_c) begin
                    if (hit_c) begin
                        state_d          = RESP;
                        m_result_d       = select_half(cache_product_c, ex_funct3);
                        m_result_valid_d = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        mul_start_d = 1'b1;
                        mul_a_d     = {(req_cls_c != UU) & rs1_data[XLEN-1], rs1_data};
                        mul_b_d     = {(req_cls_c == SS) & rs2_data[XLEN-1], rs2_data};
                        f3_d        = ex_funct3;
                    end
                end
            end
            ISSUE, WAIT: begin
                if (flush) begin
                    // A completion coinciding with the flush needs no drain.
                    state_d = mul_done ? IDLE : DRAIN;
                end else if (mul_done) begin
                    state_d          = RESP;
                    m_result_d       = select_half(mul_product[2*XLEN-1:0], f3_q);
                    m_result_valid_d = 1'b1;
                    cache_wr_c       = 1'b1;
                end else if ((state_q == WAIT) && (cnt_q >= CNT_W'(TIMEOUT - 1))) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = (state_q == ISSUE) ? '0 : cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (mul_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            mul_start_q      <= 1'b0;
            mul_a_q          <= '0;
            mul_b_q          <= '0;
            f3_q             <= '0;
            m_result_q       <= '0;
            m_result_valid_q <= 1'b0;
            timeout_err_q    <= 1'b0;
            cnt_q            <= '0;
        end else begin
            state_q          <= state_d;
            mul_start_q      <= mul_start_d;
            mul_a_q          <= mul_a_d;
            mul_b_q          <= mul_b_d;
            f3_q             <= f3_d;
            m_result_q       <= m_result_d;
            m_result_valid_q <= m_result_valid_d;
            timeout_err_q    <= timeout_err_d;
            cnt_q            <= cnt_d;
        end
    end

    // Stall follows the request combinationally so the pipeline freezes in cycle 0.
    assign m_stall = ~rst & ((req_c & (state_q != RESP))
                             | (state_q == ISSUE) | (state_q == WAIT) | (state_q == DRAIN));

    assign mul_start      = mul_start_q;
    assign mul_a          = mul_a_q;
    assign mul_b          = mul_b_q;
    assign m_result       = m_result_q;
    assign m_result_valid = m_result_valid_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: doc/mul_issue_control.md
# mul_issue_control

Pipeline-side initiator for the iterative multiplier in the M-extension datapath. Sits in EX: detects MUL/MULH/MULHSU/MULHU, sign-extends and latches operands, pulses the multiplier start (`is_mul`), stalls the pipeline until the multiplier's one-cycle `done`, selects the 32-bit result half, and returns it with a one-cycle valid. Keeps a one-entry product cache so a MULH[S][U]/MUL pair on identical operands issues the multiplier only once.

## Interface
- `TIMEOUT`, 16: max cycles in WAIT before error.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  EX stage holds a valid instruction.
- `ex_is_m`  in  1  instruction is OP with funct7=0000001.
- `ex_funct3`  in  3  M-extension funct3; requests only when funct3[2]=0.
- `rs1_data`, `rs2_data`  in  32 each  source operands, stable while stalled.
- `flush`  in  1  synchronous kill of the EX instruction.
- `mul_start`  out  1  one-cycle start pulse to multiplier (`is_mul`).
- `mul_a`, `mul_b`  out  33 each  sign/zero-extended operands, registered, held from ISSUE until capture.
- `mul_done`  in  1  one-cycle completion from multiplier.
- `mul_product`  in  66  signed product of `mul_a`×`mul_b`.
- `m_stall`  out  1  freeze PC/IF/ID/EX.
- `m_result`  out  32  selected result, valid with `m_result_valid`.
- `m_result_valid`  out  1  one-cycle result strobe.
- `timeout_err`  out  1  sticky, cleared only by `rst`.

## Operation
- Request = `ex_valid & ex_is_m & ~ex_funct3[2] & ~flush`.
- Sign class: 000 MUL and 001 MULH → SS; 010 MULHSU → SU; 011 MULHU → UU. `mul_a = {sa & rs1[31], rs1}`, `mul_b = {sb & rs2[31], rs2}`.
- Result: funct3=000 → `product[31:0]`; otherwise `product[63:32]`.
- Cache: {valid, rs1, rs2, class, product[63:0]}; written on every captured `mul_done` not being drained. Hit = valid & rs1/rs2 equal & (class equal, or request is MUL, since low half is class-independent).
- States:
  - IDLE: hit → RESP (no `mul_start`). Miss → ISSUE, latch operands and funct3.
  - ISSUE: `mul_start`=1 → WAIT; if `mul_done` is already high, capture → RESP.
  - WAIT: `mul_done` → capture, RESP. Counter ≥ TIMEOUT → set `timeout_err`, return to IDLE, and do not write the cache.
  - RESP: `m_result_valid`=1, `m_stall`=0 → IDLE. Never relaunches while the same instruction is still visible.
  - DRAIN: entered on `flush` in ISSUE/WAIT. The multiplier cannot abort. Wait for `mul_done`, discard the product and leave the cache untouched, then go to IDLE. A new request arriving during DRAIN stalls.
- `flush` in IDLE or RESP: go to IDLE with no result strobe.
- `flush` with a request in the same cycle: the flush wins.
- Unused `ex_funct3` (1xx, divide) is ignored.

## Timing
- Reset values: state IDLE; `mul_start`, `m_result_valid`, `timeout_err`, cache valid = 0; `mul_a`/`mul_b`/`m_result` = 0; `m_stall`=0 while `rst`.
- `m_stall` = request & state≠RESP, or state ∈ {ISSUE, WAIT, DRAIN}. It is combinational from the request.
- Miss, multiplier done at cycle k after the start pulse:
  - request seen in cycle 0 (IDLE);
  - `mul_start` in cycle 1;
  - RESP in cycle 1+k+1;
  - pipeline advances at the end of RESP.
- Hit: request in cycle 0, RESP in cycle 1 (2-cycle occupancy).
- Reset mid-WAIT: immediate return to IDLE and cache invalidated. A later stray `mul_done` in IDLE is ignored.

## Structure
- In package `m_extension`:
  - funct3 encodings;
  - `sign_class_t` {SS, SU, UU};
  - issue state enum {IDLE, ISSUE, WAIT, RESP, DRAIN};
  - result-half select function.
- Sub-module `mul_result_cache`: one-entry storage plus hit compare, with write/invalidate ports.

## Test plan
- MUL, rs1=0xFFFFFFFF, rs2=0x2, cold cache → one `mul_start`, `m_stall` held until RESP, `m_result`=0xFFFFFFFE.
- Then MULHU with the same operands → miss (UU≠SS), result 0x00000001. Then MULH → miss (cache now UU), result 0xFFFFFFFF.
- MULH, then MUL on the same operands → second op has no `mul_start`, RESP one cycle after the request, result 0xFFFFFFFE.
- MULHSU, rs1=0xFFFFFFFF, rs2=0x2 → `mul_a`=0x1FFFFFFFF, `mul_b`=0x000000002, result 0xFFFFFFFF.
- `flush` in WAIT with a new request present → DRAIN; no `m_result_valid`; cache unchanged; the new request's `mul_start` comes only after the drained `mul_done`.
- `mul_done` withheld for 16 WAIT cycles → `timeout_err`=1 and stays set. Separately, `rst` pulsed mid-WAIT → all outputs 0, and the next identical request misses.
